generador_pulsos_botones: RTL and testbench
===========================================

GENERADOR_PULSOS_BOTONES -- requirements
Module: generador_pulsos_botones

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: synchronized input stable time, in clk cycles, needed to accept a level change (range 2..2^25-1).
REQ-002 Parameter HOLD_CYCLES, default 25000000: accepted-press duration, in clk cycles, before autorepeat starts.
REQ-003 Parameter REPEAT_CYCLES, default 10000000: spacing, in clk cycles, between autorepeat pulses.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 boton_aumenta_raw  input  1  raw, asynchronous, bouncing "increase" push-button level; 1 = pressed.
REQ-007 boton_disminuye_raw  input  1  raw, asynchronous, bouncing "decrease" push-button level; 1 = pressed.
REQ-008 boton_aumenta  output  1  single-cycle registered increase pulse for the year counter.
REQ-009 boton_disminuye  output  1  single-cycle registered decrease pulse for the year counter.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; s_x denotes the second flop output.
REQ-011 Each channel SHALL have an independent FSM with states IDLE, PRESS_DB, HELD, RELEASE_DB and a 25-bit cycle counter.
REQ-012 IDLE: when s_x=1, go to PRESS_DB with counter=1; otherwise stay.
REQ-013 PRESS_DB: when s_x=0, return to IDLE and clear the counter; when counter=DEBOUNCE_CYCLES-1 and s_x=1, go to HELD, clear the counter, and assert the pulse on that same edge; otherwise increment.
REQ-014 Latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles from the first clk edge sampling raw=1 to the pulse-high cycle, provided raw stays high.
REQ-015 HELD: when s_x=0, go to RELEASE_DB with counter=1; otherwise increment, saturating at 2^25-1.
REQ-016 RELEASE_DB: when s_x=1, return to HELD; when counter=DEBOUNCE_CYCLES-1 and s_x=0, go to IDLE; otherwise increment. No pulse is generated on release.
REQ-017 A pulse SHALL be high for exactly one cycle per generating event.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles on the synchronized level SHALL produce no pulse and no state change beyond the debounce state.
REQ-019 Simultaneous events: if both channels would pulse in the same cycle, boton_aumenta SHALL be asserted and that boton_disminuye pulse discarded. The outputs SHALL never be high together.
REQ-020 While one channel is in HELD, the other channel SHALL still be debounced and may pulse normally, subject to REQ-019.

Reset
REQ-021 With reset=1 at a clk edge, both FSMs SHALL enter IDLE, and the counters, synchronizer flops and both outputs SHALL become 0 on that edge.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse. After release, a still-pressed button SHALL be treated as a new press (full DEBOUNCE_CYCLES+2 latency).
REQ-023 Reset SHALL take priority over all other inputs.

Configuration
REQ-024 Macro AUTOREPEAT_EN SHALL control autorepeat.
REQ-025 With AUTOREPEAT_EN defined, HELD SHALL emit a pulse when the counter reaches HOLD_CYCLES, then every REPEAT_CYCLES cycles while s_x stays 1. The counter reloads so that pulses fall at HOLD_CYCLES, HOLD_CYCLES+REPEAT_CYCLES, and so on after the entry into HELD. These pulses obey REQ-019.
REQ-026 Without AUTOREPEAT_EN, HELD SHALL never pulse, and exactly one pulse SHALL be produced per accepted press.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-027 Clean press: aumenta_raw rises at edge 10 and is held for 12 cycles -> boton_aumenta high only at cycle 16, boton_disminuye stays 0.
REQ-028 Bounce: disminuye_raw toggles 1,0,1,0 per cycle, then holds 1 -> exactly one boton_disminuye pulse, 6 cycles after the final rise.
REQ-029 Simultaneous: both raws rise on the same edge -> boton_aumenta pulses once, boton_disminuye never pulses for that press.
REQ-030 Autorepeat (AUTOREPEAT_EN): aumenta_raw held 50 cycles -> pulses at entry+0, +20, +28, +36, +44 relative to the HELD-entry edge. Without the macro -> one pulse only.
REQ-031 Reset mid-debounce: reset for 1 cycle at the second cycle of PRESS_DB with raw held high -> no pulse before reset; one pulse 6 cycles after reset deassertion; all outputs 0 during reset.

Source files
------------

// File: rtl/generador_pulsos_botones.sv
// generador_pulsos_botones: debounced one-cycle pulses for two buttons, aumenta wins ties; define AUTOREPEAT_EN for hold-to-repeat (assumes REPEAT_CYCLES <= HOLD_CYCLES)
module generador_pulsos_botones #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_aumenta_raw,
  input  logic boton_disminuye_raw,
  output logic boton_aumenta,
  output logic boton_disminuye
);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
`ifdef AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif
  localparam logic [24:0] DB_LAST = 25'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] HOLD_LAST = 25'(HOLD_CYCLES - 1);
  localparam logic [24:0] REPEAT_LOAD = 25'(HOLD_CYCLES - REPEAT_CYCLES);
  logic [1:0] raw, pulse;
  logic aumenta_q, aumenta_d, disminuye_q, disminuye_d;
  assign raw = {boton_disminuye_raw, boton_aumenta_raw};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [1:0] sync_q, sync_d;
    logic pulse_q, pulse_d, s;
    assign s = sync_q[1];
    assign pulse[c] = pulse_q;
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pulse_d = 1'b0;
      sync_d = {sync_q[0], raw[c]};
      case (state_q)
        IDLE:
          if (s) begin
            state_d = PRESS_DB;
            cnt_d = 25'd1;
          end
        PRESS_DB:
          if (!s) begin
            state_d = IDLE;
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = HELD;
            cnt_d = '0;
            pulse_d = 1'b1;
          end else cnt_d = cnt_q + 25'd1;
        HELD:
          if (!s) begin
            state_d = RELEASE_DB;
            cnt_d = 25'd1;
          end else if (AUTOREPEAT && cnt_q == HOLD_LAST) begin
            cnt_d = REPEAT_LOAD;
            pulse_d = 1'b1;
          end else if (cnt_q != '1) cnt_d = cnt_q + 25'd1;
        default:
          if (s) begin
            state_d = HELD;
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d = '0;
          end else cnt_d = cnt_q + 25'd1;
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q <= '0;
        sync_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        sync_q <= sync_d;
        pulse_q <= pulse_d;
      end
    end
  end
  always_comb begin
    aumenta_d = pulse[0];
    disminuye_d = pulse[1] & ~pulse[0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      aumenta_q <= 1'b0;
      disminuye_q <= 1'b0;
    end else begin
      aumenta_q <= aumenta_d;
      disminuye_q <= disminuye_d;
    end
  end
  assign boton_aumenta = aumenta_q;
  assign boton_disminuye = disminuye_q;
endmodule

// File: tb/tb_generador_pulsos_botones.sv
// tb_generador_pulsos_botones: directed scenarios plus random bouncing buttons against a run-length model
module tb_generador_pulsos_botones;
  localparam int D = 4, HOLD = 20, REP = 8;
  logic clk = 1'b0, reset, aum, dis, boton_aumenta, boton_disminuye;
  int cyc = 0, n_vec = 0, n_bad = 0;
  int qa[$], qd[$];
  generador_pulsos_botones #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset), .boton_aumenta_raw(aum), .boton_disminuye_raw(dis),
    .boton_aumenta(boton_aumenta), .boton_disminuye(boton_disminuye)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bit s1[2], s2[2], last[2], pressed[2], pend[2];
  int run[2], ht[2];
  bit exp_a = 1'b0, exp_d = 1'b0;
  always @(posedge clk) begin
    bit s, prev;
    bit p[2], rv[2];
    rv[0] = aum;
    rv[1] = dis;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        s1[i] = 0; s2[i] = 0; last[i] = 0; pressed[i] = 0; pend[i] = 0; run[i] = 0; ht[i] = 0;
      end
      exp_a = 0;
      exp_d = 0;
    end else begin
      exp_a = pend[0];
      exp_d = pend[1] & ~pend[0];
      for (int i = 0; i < 2; i++) begin
        s = s2[i];
        prev = last[i];
        run[i] = (s == prev) ? run[i] + 1 : 1;
        last[i] = s;
        p[i] = 0;
        if (!pressed[i]) begin
          if (s && run[i] == D) begin pressed[i] = 1; p[i] = 1; ht[i] = 0; end
        end else if (s) begin
          ht[i] = prev ? ht[i] + 1 : 0;
`ifdef AUTOREPEAT_EN
          if (ht[i] >= HOLD && (ht[i] - HOLD) % REP == 0) p[i] = 1;
`endif
        end else if (run[i] == D) pressed[i] = 0;
        pend[i] = p[i];
        s2[i] = s1[i];
        s1[i] = rv[i];
      end
    end
  end
  always @(negedge clk) begin
    n_vec++;
    if (boton_aumenta !== exp_a || boton_disminuye !== exp_d) begin
      n_bad++;
      $display("FAIL outputs at cycle %0d: got aumenta=%b disminuye=%b, expected %b %b",
               cyc, boton_aumenta, boton_disminuye, exp_a, exp_d);
    end
    if (boton_aumenta) qa.push_back(cyc);
    if (boton_disminuye) qd.push_back(cyc);
  end
  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
  function automatic int get(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int f;
    int rem[2];
    bit lvl[2];
`ifdef AUTOREPEAT_EN
    int rep_off[5] = '{0, 20, 28, 36, 44};
`endif
    reset = 1; aum = 0; dis = 0;
    settle(1);
    chk("reset_aumenta", int'(boton_aumenta), 0);
    chk("reset_disminuye", int'(boton_disminuye), 0);
    settle(2);
    reset = 0;
    while (cyc < 9) @(negedge clk);
    qa.delete(); qd.delete();
    aum = 1;
    settle(12); aum = 0; settle(20);
    chk("clean_count", qa.size(), 1);
    chk("clean_cycle", get(qa, 0), 16);
    chk("clean_no_dis", qd.size(), 0);
    qa.delete(); qd.delete();
    dis = 1; settle(1); dis = 0; settle(1); dis = 1; settle(1); dis = 0; settle(1);
    dis = 1; f = cyc + 1;
    settle(15); dis = 0; settle(15);
    chk("bounce_count", qd.size(), 1);
    chk("bounce_cycle", get(qd, 0), f + 6);
    chk("bounce_no_aum", qa.size(), 0);
    qa.delete(); qd.delete();
    aum = 1; dis = 1; f = cyc + 1;
    settle(12); aum = 0; dis = 0; settle(15);
    chk("simul_aum_count", qa.size(), 1);
    chk("simul_aum_cycle", get(qa, 0), f + 6);
    chk("simul_dis_count", qd.size(), 0);
    qa.delete(); qd.delete();
    aum = 1; f = cyc + 1;
    settle(50); aum = 0; settle(15);
`ifdef AUTOREPEAT_EN
    chk("repeat_count", qa.size(), 5);
    for (int i = 0; i < 5; i++) chk("repeat_cycle", get(qa, i), f + 6 + rep_off[i]);
`else
    chk("hold_count", qa.size(), 1);
    chk("hold_cycle", get(qa, 0), f + 6);
`endif
    qa.delete(); qd.delete();
    aum = 1; f = cyc + 1;
    settle(3); reset = 1;
    settle(1);
    chk("midreset_aumenta", int'(boton_aumenta), 0);
    chk("midreset_disminuye", int'(boton_disminuye), 0);
    reset = 0;
    settle(15); aum = 0; settle(15);
    chk("midreset_count", qa.size(), 1);
    chk("midreset_cycle", get(qa, 0), f + 10);
    rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          int r;
          r = $urandom_range(0, 9);
          lvl[i] = !lvl[i];
          rem[i] = (r < 4) ? $urandom_range(1, 3) : (r < 8) ? $urandom_range(4, 10) : $urandom_range(20, 60);
        end
        rem[i]--;
      end
      aum = lvl[0];
      dis = lvl[1];
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 0; aum = 0; dis = 0;
    settle(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
